// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32 core: csrrw/csrrs/csrrc access,
// mcycle/minstret counters, trap entry and mret return.
module csr_file #(
    parameter int unsigned CNT_W       = 64,
    parameter bit          HAS_INSTRET = 1'b1,
    parameter logic [31:0] MVENDORID   = 32'h79737978,
    parameter logic [31:0] MARCHID     = 32'h017eb18f,
    parameter logic [31:0] MTVEC_RST   = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        inst_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    csr_op_e op;
    assign op = csr_op_e'(csr_op);

    logic             mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0]      mtvec_q, mtvec_d;
    logic [31:0]      mscratch_q, mscratch_d;
    logic [31:0]      mepc_q, mepc_d;
    logic [31:0]      mcause_q, mcause_d;
    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;

    // Counters are viewed as 64 bits so the high-half slice exists for any CNT_W.
    logic [63:0] mcycle_x, minstret_x;
    assign mcycle_x   = 64'(mcycle_q);
    assign minstret_x = 64'(minstret_q);

    logic [31:0] mstatus_rd;
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    logic        known, read_only;
    logic [31:0] rdata;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        known     = 1'b1;
        read_only = 1'b0;
        rdata     = '0;
        case (csr_addr)
            A_MSTATUS:   rdata = mstatus_rd;
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MCYCLE:    rdata = mcycle_x[31:0];
            A_MCYCLEH:   rdata = mcycle_x[63:32];
            A_MINSTRET:  rdata = minstret_x[31:0];
            A_MINSTRETH: rdata = minstret_x[63:32];
            A_MVENDORID: begin rdata = MVENDORID; read_only = 1'b1; end
            A_MARCHID:   begin rdata = MARCHID;   read_only = 1'b1; end
            default:     known = 1'b0;
        endcase
    end

    logic        active, wants_write, wr_en;
    logic [31:0] wval;

    // Set/clear with a zero mask is a pure read, so it never counts as a write.
    assign active      = csr_valid && (op != OP_NONE);
    assign wants_write = (op == OP_RW) || (csr_wdata != '0);
    assign csr_illegal = active && (!known || (read_only && wants_write));
    assign wr_en       = active && known && !read_only && wants_write && !trap_valid;
    assign csr_rdata   = rdata;

    always_comb begin
        case (op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = rdata | csr_wdata;
            OP_RC:   wval = rdata & ~csr_wdata;
            default: wval = rdata;
        endcase
    end

    logic [63:0] mcycle_nx, minstret_nx;
    logic        cyc_wr, ret_wr;

    always_comb begin
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mcycle_nx   = mcycle_x;
        minstret_nx = minstret_x;
        cyc_wr      = 1'b0;
        ret_wr      = 1'b0;

        if (wr_en && csr_addr == A_MCYCLE) begin
            mcycle_nx[31:0] = wval;
            cyc_wr          = 1'b1;
        end
        if (wr_en && csr_addr == A_MCYCLEH && CNT_W > 32) begin
            mcycle_nx[63:32] = wval;
            cyc_wr           = 1'b1;
        end
        if (wr_en && csr_addr == A_MINSTRET) begin
            minstret_nx[31:0] = wval;
            ret_wr            = 1'b1;
        end
        if (wr_en && csr_addr == A_MINSTRETH && CNT_W > 32) begin
            minstret_nx[63:32] = wval;
            ret_wr             = 1'b1;
        end

        mcycle_d = cyc_wr ? mcycle_nx[CNT_W-1:0] : mcycle_q + CNT_W'(1);
        if (ret_wr) begin
            minstret_d = minstret_nx[CNT_W-1:0];
        end else if (inst_retire) begin
            minstret_d = minstret_q + CNT_W'(1);
        end else begin
            minstret_d = minstret_q;
        end
        if (!HAS_INSTRET) begin
            minstret_d = '0;
        end

        if (wr_en) begin
            case (csr_addr)
                A_MTVEC:    mtvec_d    = wval & ~32'h3;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = wval & ~32'h3;
                A_MCAUSE:   mcause_d   = wval;
                default:    ;
            endcase
        end

        // Trap entry outranks mret, which outranks a software write to mstatus.
        if (trap_valid) begin
            mepc_d   = trap_pc & ~32'h3;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en && csr_addr == A_MSTATUS) begin
            mie_d  = wval[3];
            mpie_d = wval[7];
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;

endmodule
